fios_mm_sequencer: RTL and testbench

// - Operand/result sequencer wrapped around one FIOS_NOCASC Montgomery core.
// - Holds s-word a/b/p operand buffers and p'_0, launches the core, and serves its b_fetch/p_fetch/a_shift requests.
// - Captures the s result words on RES_push and hands completion back to the host with a start/busy/done handshake.

---
 rtl/fios_pkg.sv | 28 ++
 rtl/fios_word_buf.sv | 46 ++++
 rtl/fios_mm_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_fios_mm_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fios_pkg.sv
// ============================================================================
// Module      : fios_pkg
// Description : Shared word type, sequencer states and operand-select codes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fios_pkg;

  localparam int WORD_W = 17;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

  localparam logic [1:0] OP_A   = 2'd0;
  localparam logic [1:0] OP_B   = 2'd1;
  localparam logic [1:0] OP_P   = 2'd2;
  localparam logic [1:0] OP_PP0 = 2'd3;

endpackage

`default_nettype wire

// File: rtl/fios_word_buf.sv
// ============================================================================
// Module      : fios_word_buf
// Description : DEPTH x 17 buffer, one write port, registered enabled read.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fios_word_buf
  import fios_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  word_t         wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output word_t         rdata_o
);

  word_t r_mem [DEPTH];
  word_t r_rdata;

  // Storage is deliberately left out of reset; only the read register clears.
  always_ff @(posedge clock_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_rdata <= '0;
    end else if (re_i) begin
      r_rdata <= r_mem[raddr_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule

`default_nettype wire

// File: rtl/fios_mm_sequencer.sv
// ============================================================================
// Module      : fios_mm_sequencer
// Description : Operand/result sequencer around one FIOS_NOCASC Montgomery core.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fios_mm_sequencer
  import fios_pkg::*;
#(
  parameter int S     = 8,
  parameter int PE_NB = S,
  parameter int AW    = (S > 1) ? $clog2(S) : 1
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      op_we_i,
  input  logic [1:0]                op_sel_i,
  input  logic [AW-1:0]             op_addr_i,
  input  logic [WORD_W-1:0]         op_data_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  input  logic [AW-1:0]             res_rd_addr_i,
  output logic [WORD_W-1:0]         res_rd_data_o,
  output logic                      core_start_o,
  output logic [WORD_W-1:0]         core_p_prime_0_o,
  output logic [PE_NB*WORD_W-1:0]   core_a_o,
  output logic [WORD_W-1:0]         core_b_o,
  output logic [WORD_W-1:0]         core_p_o,
  input  logic                      core_a_shift_i,
  input  logic                      core_b_fetch_i,
  input  logic                      core_p_fetch_i,
  input  logic                      core_res_push_i,
  input  logic [WORD_W-1:0]         core_res_i,
  input  logic                      core_done_i
);

  localparam int CW = AW + 1;
  // Base can overshoot S by up to PE_NB-1 before saturating; window adds PE_NB-1 more.
  localparam int BW = $clog2(S + 2 * PE_NB);

  localparam logic [1:0] c_ST_IDLE   = IDLE;
  localparam logic [1:0] c_ST_LAUNCH = LAUNCH;
  localparam logic [1:0] c_ST_RUN    = RUN;
  localparam logic [1:0] c_ST_DONE   = DONE;

  localparam logic [AW-1:0] c_PTR_LAST = AW'(S - 1);
  localparam logic [CW-1:0] c_CNT_FULL = CW'(S);
  localparam logic [BW-1:0] c_BASE_END = BW'(S);
  localparam logic [BW-1:0] c_BASE_INC = BW'(PE_NB);

  logic [1:0]    r_state;
  logic [AW-1:0] r_b_ptr;
  logic [AW-1:0] r_p_ptr;
  logic [BW-1:0] r_a_base;
  logic [CW-1:0] r_res_cnt;
  logic          r_err;
  word_t         r_pp0;
  word_t         r_a [S];

  logic          w_idle;
  logic          w_run;
  logic          w_host_we;
  logic          w_b_fetch;
  logic          w_p_fetch;
  logic          w_push;
  logic          w_push_ok;
  logic [CW-1:0] w_res_cnt_nxt;
  logic          w_err_set;

  assign w_idle    = (r_state == c_ST_IDLE);
  assign w_run     = (r_state == c_ST_RUN);
  assign w_host_we = op_we_i & w_idle;
  assign w_b_fetch = w_run & core_b_fetch_i;
  assign w_p_fetch = w_run & core_p_fetch_i;
  assign w_push    = w_run & core_res_push_i;
  assign w_push_ok = w_push & (r_res_cnt < c_CNT_FULL);

  // A push landing with core_done_i counts before the completeness check.
  assign w_res_cnt_nxt = w_push_ok ? (r_res_cnt + CW'(1)) : r_res_cnt;
  assign w_err_set     = (w_push & ~w_push_ok) |
                         (w_run & core_done_i & (w_res_cnt_nxt != c_CNT_FULL));

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state   <= c_ST_IDLE;
      r_b_ptr   <= '0;
      r_p_ptr   <= '0;
      r_a_base  <= '0;
      r_res_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (start_i) begin
            r_state <= c_ST_LAUNCH;
          end
        end
        c_ST_LAUNCH: begin
          r_state   <= c_ST_RUN;
          r_b_ptr   <= '0;
          r_p_ptr   <= '0;
          r_a_base  <= '0;
          r_res_cnt <= '0;
          r_err     <= 1'b0;
        end
        c_ST_RUN: begin
          if (core_done_i) begin
            r_state <= c_ST_DONE;
          end
          if (w_b_fetch) begin
            r_b_ptr <= (r_b_ptr == c_PTR_LAST) ? '0 : r_b_ptr + AW'(1);
          end
          if (w_p_fetch) begin
            r_p_ptr <= (r_p_ptr == c_PTR_LAST) ? '0 : r_p_ptr + AW'(1);
          end
          if (core_a_shift_i && (r_a_base < c_BASE_END)) begin
            r_a_base <= r_a_base + c_BASE_INC;
          end
          r_res_cnt <= w_res_cnt_nxt;
          if (w_err_set) begin
            r_err <= 1'b1;
          end
        end
        c_ST_DONE: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (w_host_we && (op_sel_i == OP_A)) begin
      r_a[op_addr_i] <= op_data_i;
    end
    if (w_host_we && (op_sel_i == OP_PP0)) begin
      r_pp0 <= op_data_i;
    end
  end

  fios_word_buf #(.DEPTH(S), .AW(AW)) u_b_buf (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .we_i    (w_host_we & (op_sel_i == OP_B)),
    .waddr_i (op_addr_i),
    .wdata_i (op_data_i),
    .re_i    (w_b_fetch),
    .raddr_i (r_b_ptr),
    .rdata_o (core_b_o)
  );

  fios_word_buf #(.DEPTH(S), .AW(AW)) u_p_buf (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .we_i    (w_host_we & (op_sel_i == OP_P)),
    .waddr_i (op_addr_i),
    .wdata_i (op_data_i),
    .re_i    (w_p_fetch),
    .raddr_i (r_p_ptr),
    .rdata_o (core_p_o)
  );

  fios_word_buf #(.DEPTH(S), .AW(AW)) u_res_buf (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .we_i    (w_push_ok),
    .waddr_i (r_res_cnt[AW-1:0]),
    .wdata_i (core_res_i),
    .re_i    (1'b1),
    .raddr_i (res_rd_addr_i),
    .rdata_o (res_rd_data_o)
  );

  for (genvar k = 0; k < PE_NB; k++) begin : g_window
    localparam logic [BW-1:0] c_K = BW'(k);
    logic [BW-1:0] w_idx;
    assign w_idx = r_a_base + c_K;
    assign core_a_o[k*WORD_W +: WORD_W] = (w_idx < c_BASE_END) ? r_a[w_idx[AW-1:0]] : '0;
  end

  assign busy_o           = ~w_idle;
  assign done_o           = (r_state == c_ST_DONE);
  assign core_start_o     = (r_state == c_ST_LAUNCH);
  assign err_o            = r_err;
  assign core_p_prime_0_o = r_pp0;

endmodule

`default_nettype wire

// File: tb/tb_fios_mm_sequencer.sv
// ============================================================================
// Module      : tb_fios_mm_sequencer
// Description : Directed self-checking bench for fios_mm_sequencer (S=8, PE_NB=3).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fios_mm_sequencer;

  localparam int S     = 8;
  localparam int PE_NB = 3;
  localparam int AW    = 3;

  logic                  clock_i = 1'b0;
  logic                  reset_i = 1'b1;
  logic                  op_we_i = 1'b0;
  logic [1:0]            op_sel_i = 2'd0;
  logic [AW-1:0]         op_addr_i = '0;
  logic [16:0]           op_data_i = '0;
  logic                  start_i = 1'b0;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  logic [AW-1:0]         res_rd_addr_i = '0;
  logic [16:0]           res_rd_data_o;
  logic                  core_start_o;
  logic [16:0]           core_p_prime_0_o;
  logic [PE_NB*17-1:0]   core_a_o;
  logic [16:0]           core_b_o;
  logic [16:0]           core_p_o;
  logic                  core_a_shift_i = 1'b0;
  logic                  core_b_fetch_i = 1'b0;
  logic                  core_p_fetch_i = 1'b0;
  logic                  core_res_push_i = 1'b0;
  logic [16:0]           core_res_i = '0;
  logic                  core_done_i = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  fios_mm_sequencer #(.S(S), .PE_NB(PE_NB), .AW(AW)) dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .op_we_i          (op_we_i),
    .op_sel_i         (op_sel_i),
    .op_addr_i        (op_addr_i),
    .op_data_i        (op_data_i),
    .start_i          (start_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .res_rd_addr_i    (res_rd_addr_i),
    .res_rd_data_o    (res_rd_data_o),
    .core_start_o     (core_start_o),
    .core_p_prime_0_o (core_p_prime_0_o),
    .core_a_o         (core_a_o),
    .core_b_o         (core_b_o),
    .core_p_o         (core_p_o),
    .core_a_shift_i   (core_a_shift_i),
    .core_b_fetch_i   (core_b_fetch_i),
    .core_p_fetch_i   (core_p_fetch_i),
    .core_res_push_i  (core_res_push_i),
    .core_res_i       (core_res_i),
    .core_done_i      (core_done_i)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_op(input logic [1:0] sel, input int addr, input logic [16:0] data);
    op_we_i   = 1'b1;
    op_sel_i  = sel;
    op_addr_i = AW'(addr);
    op_data_i = data;
    tick();
    op_we_i   = 1'b0;
  endtask

  task automatic start_run();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
  endtask

  task automatic push(input logic [16:0] data, input logic with_done);
    core_res_push_i = 1'b1;
    core_res_i      = data;
    core_done_i     = with_done;
    tick();
    core_res_push_i = 1'b0;
    core_done_i     = 1'b0;
  endtask

  task automatic finish_run();
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
  endtask

  task automatic read_res(input int addr, input logic [16:0] exp, input string tag);
    res_rd_addr_i = AW'(addr);
    tick();
    check(tag, 64'(res_rd_data_o), 64'(exp));
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_err", 64'(err_o), 64'(0));
    check("rst_cstart", 64'(core_start_o), 64'(0));
    check("rst_b", 64'(core_b_o), 64'(0));
    check("rst_p", 64'(core_p_o), 64'(0));
    check("rst_rd", 64'(res_rd_data_o), 64'(0));
    reset_i = 1'b0;
    tick();

    for (int i = 0; i < S; i++) write_op(2'd0, i, 17'(i + 1));
    for (int i = 0; i < S; i++) write_op(2'd1, i, 17'(i + 1));
    for (int i = 0; i < S; i++) write_op(2'd2, i, 17'(i + 1));
    write_op(2'd3, 0, 17'h1FFFF);
    check("pp0", 64'(core_p_prime_0_o), 64'(17'h1FFFF));
    check("win0_idle", 64'(core_a_o), 64'({17'd3, 17'd2, 17'd1}));

    // Launch: start pulse one cycle after start_i
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("launch_cstart", 64'(core_start_o), 64'(1));
    check("launch_busy", 64'(busy_o), 64'(1));
    tick();
    check("run_cstart", 64'(core_start_o), 64'(0));
    check("run_busy", 64'(busy_o), 64'(1));

    // 16 simultaneous b/p fetches wrap through 1..8 twice
    core_b_fetch_i = 1'b1;
    core_p_fetch_i = 1'b1;
    for (int i = 0; i < 2 * S; i++) begin
      tick();
      check("b_fetch", 64'(core_b_o), 64'((i % S) + 1));
      check("p_fetch", 64'(core_p_o), 64'((i % S) + 1));
    end
    core_b_fetch_i = 1'b0;
    core_p_fetch_i = 1'b0;
    tick();
    check("b_hold", 64'(core_b_o), 64'(8));

    // a window shifts
    check("win_base0", 64'(core_a_o), 64'({17'd3, 17'd2, 17'd1}));
    core_a_shift_i = 1'b1; tick(); core_a_shift_i = 1'b0;
    check("win_shift1", 64'(core_a_o), 64'({17'd6, 17'd5, 17'd4}));
    core_a_shift_i = 1'b1; tick(); core_a_shift_i = 1'b0;
    check("win_shift2", 64'(core_a_o), 64'({17'd0, 17'd8, 17'd7}));
    core_a_shift_i = 1'b1; tick(); core_a_shift_i = 1'b0;
    check("win_shift3", 64'(core_a_o), 64'(0));
    core_a_shift_i = 1'b1; tick(); core_a_shift_i = 1'b0;
    check("win_shift4", 64'(core_a_o), 64'(0));

    // Host writes and start while busy are dropped
    op_we_i = 1'b1; op_sel_i = 2'd1; op_addr_i = '0; op_data_i = 17'h55;
    start_i = 1'b1;
    tick();
    op_sel_i = 2'd0;
    start_i = 1'b0;
    check("busy_start_ign", 64'(core_start_o), 64'(0));
    tick();
    op_we_i = 1'b0;
    check("busy_still", 64'(busy_o), 64'(1));
    core_b_fetch_i = 1'b1; tick(); core_b_fetch_i = 1'b0;
    check("b0_unchanged", 64'(core_b_o), 64'(1));

    // Run 1: exactly S pushes
    for (int i = 0; i < S; i++) push(17'h100 + 17'(i), 1'b0);
    finish_run();
    check("r1_done", 64'(done_o), 64'(1));
    check("r1_err", 64'(err_o), 64'(0));
    tick();
    check("r1_done_pulse", 64'(done_o), 64'(0));
    check("r1_busy_off", 64'(busy_o), 64'(0));
    read_res(5, 17'h105, "r1_res5");
    read_res(0, 17'h100, "r1_res0");

    // Run 2: one push too many
    start_run();
    check("r2_win_a0", 64'(core_a_o), 64'({17'd3, 17'd2, 17'd1}));
    for (int i = 0; i < S + 1; i++) push(17'h200 + 17'(i), 1'b0);
    check("r2_err_overflow", 64'(err_o), 64'(1));
    finish_run();
    check("r2_done", 64'(done_o), 64'(1));
    check("r2_err_done", 64'(err_o), 64'(1));
    tick();
    read_res(0, 17'h200, "r2_res0");
    read_res(7, 17'h207, "r2_res7");

    // Run 3: one push short
    start_run();
    check("r3_err_clr", 64'(err_o), 64'(0));
    for (int i = 0; i < S - 1; i++) push(17'h300 + 17'(i), 1'b0);
    finish_run();
    check("r3_done", 64'(done_o), 64'(1));
    check("r3_err_short", 64'(err_o), 64'(1));
    tick();
    read_res(6, 17'h306, "r3_res6");
    read_res(7, 17'h207, "r3_res7");

    // Run 4: last push coincides with core_done_i
    start_run();
    for (int i = 0; i < S - 1; i++) push(17'h400 + 17'(i), 1'b0);
    push(17'h407, 1'b1);
    check("r4_done", 64'(done_o), 64'(1));
    check("r4_err", 64'(err_o), 64'(0));
    tick();
    read_res(7, 17'h407, "r4_res7");

    // Core inputs outside RUN are ignored
    push(17'h3FF, 1'b0);
    core_b_fetch_i = 1'b1; tick(); core_b_fetch_i = 1'b0;
    check("idle_b_hold", 64'(core_b_o), 64'(1));
    check("idle_busy", 64'(busy_o), 64'(0));
    read_res(0, 17'h400, "idle_push_ign");

    // Reset mid-RUN
    start_run();
    check("r5_busy", 64'(busy_o), 64'(1));
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("mid_rst_busy", 64'(busy_o), 64'(0));
    check("mid_rst_b", 64'(core_b_o), 64'(0));
    tick();
    check("mid_rst_idle", 64'(busy_o), 64'(0));
    check("mid_rst_cstart", 64'(core_start_o), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
